// File: rtl/transpose_pkg.sv
// Shared types, default sizes and the lane extraction helper for matrix_transpose_stream.
package transpose_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  localparam int unsigned ELEM_W_DEF = 8;
  localparam int unsigned N_DEF      = 4;

  // Upper bounds for the helper's argument and return types.
  localparam int unsigned MAX_REG_W  = 1024;
  localparam int unsigned MAX_ELEM_W = 64;

  // Returns lane k of a packed row of n lanes; lane 0 sits in the most significant bits.
  // The caller narrows the result to its own element width.
  function automatic logic [MAX_ELEM_W-1:0] lane_sel(input logic [MAX_REG_W-1:0] row,
                                                     input int unsigned k,
                                                     input int unsigned n,
                                                     input int unsigned elem_w);
    return MAX_ELEM_W'(row >> ((n - 1 - k) * elem_w));
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One N x N element store with a row write port and a combinational transposed/raw row read.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned N      = N_DEF,
  localparam int unsigned RowW  = $clog2(N),
  localparam int unsigned RegW  = ELEM_W * N
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [RowW-1:0] wr_row_i,
  input  logic [RegW-1:0] wr_data_i,
  input  logic            wr_mode_i,
  input  logic [RowW-1:0] rd_row_i,
  output logic [RegW-1:0] rd_data_o
);

  logic [ELEM_W-1:0] mem_q [N][N];
  logic              mode_q;

  // Row write; the mode bit is captured only with row 0 of a matrix.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          mem_q[r][k] <= '0;
        end
      end
      mode_q <= 1'b0;
    end else if (we_i) begin
      for (int k = 0; k < N; k++) begin
        mem_q[wr_row_i][k] <= ELEM_W'(lane_sel(MAX_REG_W'(wr_data_i), k, N, ELEM_W));
      end
      if (wr_row_i == '0) begin
        mode_q <= wr_mode_i;
      end
    end
  end

  // Transpose reads column rd_row_i (input row 0 in the MSBs); passthrough reads the row as stored.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < N; k++) begin
      rd_data_o[RegW-1-k*ELEM_W -: ELEM_W] = mode_q ? mem_q[rd_row_i][k] : mem_q[k][rd_row_i];
    end
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming N x N transpose with ping-pong banks and valid/ready on both sides.
// Optional: define MATRIX_TRANSPOSE_STREAM_COUNT_EN to add the mat_count output.
module matrix_transpose_stream
  import transpose_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned N      = N_DEF,
  localparam int unsigned RegSize = ELEM_W * N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RegSize-1:0] in_row,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RegSize-1:0] out_row,
  output logic               out_last
`ifdef MATRIX_TRANSPOSE_STREAM_COUNT_EN
  ,
  output logic [31:0]        mat_count
`endif
);

  localparam int unsigned RowW = $clog2(N);
  localparam logic [RowW-1:0] LastRow = RowW'(N - 1);

  bank_state_t     state_q [2];
  bank_state_t     state_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [RowW-1:0] wr_row_q, wr_row_d;
  logic [RowW-1:0] rd_row_q, rd_row_d;

  logic               clr;
  logic               accept;
  logic               xfer;
  logic [RegSize-1:0] rd_data0, rd_data1;

  assign clr       = rst | flush;
  assign in_ready  = (state_q[wr_bank_q] != FULL);
  assign out_valid = (state_q[rd_bank_q] == FULL);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_last  = out_valid & (rd_row_q == LastRow);
  assign out_row   = out_valid ? (rd_bank_q ? rd_data1 : rd_data0) : '0;

  transpose_bank #(
    .ELEM_W (ELEM_W),
    .N      (N)
  ) u_bank0 (
    .clk       (clk),
    .clr_i     (clr),
    .we_i      (accept & ~wr_bank_q),
    .wr_row_i  (wr_row_q),
    .wr_data_i (in_row),
    .wr_mode_i (in_mode),
    .rd_row_i  (rd_row_q),
    .rd_data_o (rd_data0)
  );

  transpose_bank #(
    .ELEM_W (ELEM_W),
    .N      (N)
  ) u_bank1 (
    .clk       (clk),
    .clr_i     (clr),
    .we_i      (accept & wr_bank_q),
    .wr_row_i  (wr_row_q),
    .wr_data_i (in_row),
    .wr_mode_i (in_mode),
    .rd_row_i  (rd_row_q),
    .rd_data_o (rd_data1)
  );

  // Pointer and bank-state update; accept and transfer always target different banks.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    rd_row_d   = rd_row_q;
    if (accept) begin
      if (wr_row_q == LastRow) begin
        state_d[wr_bank_q] = FULL;
        wr_row_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
        wr_row_d           = wr_row_q + RowW'(1);
      end
    end
    if (xfer) begin
      if (rd_row_q == LastRow) begin
        state_d[rd_bank_q] = EMPTY;
        rd_row_d           = '0;
        rd_bank_d          = ~rd_bank_q;
      end else begin
        rd_row_d = rd_row_q + RowW'(1);
      end
    end
  end

  // State registers; flush clears exactly like reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_row_q   <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_row_q   <= rd_row_d;
    end
  end

`ifdef MATRIX_TRANSPOSE_STREAM_COUNT_EN
  logic [31:0] mat_count_q;

  // Completed-matrix counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (clr) begin
      mat_count_q <= '0;
    end else if (xfer && out_last) begin
      mat_count_q <= mat_count_q + 32'd1;
    end
  end

  assign mat_count = mat_count_q;
`endif

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Directed self-checking bench for matrix_transpose_stream (N=4, ELEM_W=8).
module tb_matrix_transpose_stream;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_mode, out_ready;
  logic        in_ready, out_valid, out_last;
  logic [31:0] in_row, out_row;
`ifdef MATRIX_TRANSPOSE_STREAM_COUNT_EN
  logic [31:0] mat_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int acc;

  // Matrices A, B, C and their hand-computed transposes.
  logic [31:0] rows [12] = '{
    32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233,
    32'h40414243, 32'h50515253, 32'h60616263, 32'h70717273,
    32'h80818283, 32'h90919293, 32'hA0A1A2A3, 32'hB0B1B2B3};
  logic [31:0] trs [12] = '{
    32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333,
    32'h40506070, 32'h41516171, 32'h42526272, 32'h43536373,
    32'h8090A0B0, 32'h8191A1B1, 32'h8292A2B2, 32'h8393A3B3};

  matrix_transpose_stream #(
    .ELEM_W (8),
    .N      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last)
`ifdef MATRIX_TRANSPOSE_STREAM_COUNT_EN
    ,
    .mat_count (mat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push four rows of one matrix; mode is offered only with row 0.
  task automatic push4(input int base, input logic mode);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_row   = rows[base+k];
      in_mode  = (k == 0) ? mode : 1'b0;
      #1;
      chk("push_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Drain four rows with out_ready high and compare against raw or transposed rows.
  task automatic drain4(input int base, input logic raw);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_row", out_row, raw ? rows[base+k] : trs[base+k]);
      chk("drain_last", {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
    in_row = 32'hDEADBEEF;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_row", out_row, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);

    // Test 1: single transpose, output appears the cycle after the 4th accept.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_row = rows[k]; in_mode = 1'b0;
      #1;
      chk("t1_no_early_out", {31'd0, out_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    drain4(0, 1'b0);
    #1;
    chk("t1_idle", {31'd0, out_valid}, 32'd0);

    // Test 2: two matrices back-to-back, in_ready steady and outputs contiguous.
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_row   = (c < 8) ? rows[c] : 32'h0;
      in_mode  = 1'b0;
      #1;
      if (c < 8) chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
      if (c >= 4) begin
        chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_out_row", out_row, trs[c-4]);
        chk("t2_out_last", {31'd0, out_last}, ((c % 4) == 3) ? 32'd1 : 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t2_idle", {31'd0, out_valid}, 32'd0);

    // Test 3: backpressure fills both banks; in_ready drops after 8 accepts.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_row = rows[acc]; in_mode = 1'b0;
      #1;
      chk("t3_in_ready", {31'd0, in_ready}, (c < 8) ? 32'd1 : 32'd0);
      if (c >= 5) chk("t3_hold_row", out_row, trs[0]);
      if (in_ready) acc++;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_blocked", {31'd0, in_ready}, 32'd0);
      chk("t3_drainA", out_row, trs[k]);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      in_row = rows[8+k];
      #1;
      chk("t3_resume_ready", {31'd0, in_ready}, 32'd1);
      chk("t3_drainB", out_row, trs[4+k]);
      tick();
    end
    in_valid = 1'b0;
    drain4(8, 1'b0);

    // Test 4: passthrough matrix followed by a transposed one.
    push4(0, 1'b1);
    drain4(0, 1'b1);
    push4(4, 1'b0);
    drain4(4, 1'b0);

    // Test 5a: flush after two rows discards the partial matrix.
    in_valid = 1'b1; in_row = rows[4]; tick();
    in_row = rows[5]; tick();
    flush = 1'b1; in_row = rows[6]; tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5a_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5a_in_ready", {31'd0, in_ready}, 32'd1);
    push4(0, 1'b0);
    drain4(0, 1'b0);

    // Test 5b: flush during a drain.
    push4(4, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("t5b_pre_valid", {31'd0, out_valid}, 32'd1);
    tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    #1;
    chk("t5b_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5b_out_row", out_row, 32'd0);
    chk("t5b_in_ready", {31'd0, in_ready}, 32'd1);
    push4(8, 1'b0);
    drain4(8, 1'b0);

`ifdef MATRIX_TRANSPOSE_STREAM_COUNT_EN
    // Test 6: matrix counter and reset mid-drain.
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("t6_cnt_rst", mat_count, 32'd0);
    for (int m = 0; m < 3; m++) begin
      push4(4 * m, 1'b0);
      drain4(4 * m, 1'b0);
    end
    #1;
    chk("t6_cnt3", mat_count, 32'd3);
    push4(0, 1'b0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("t6_cnt_clr", mat_count, 32'd0);
    chk("t6_valid_clr", {31'd0, out_valid}, 32'd0);
    chk("t6_row_clr", out_row, 32'd0);
`else
    // Reset mid-drain clears the output side.
    push4(0, 1'b0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_row", out_row, 32'd0);
    chk("rst_mid_last", {31'd0, out_last}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_transpose_stream.md
Name: matrix_transpose_stream

Overview:
Streaming, parametrised N×N element transpose for the execute stage.
- Accepts one packed row per cycle over a valid/ready handshake and collects N rows into a buffer bank.
- Drains the transposed matrix one row per cycle over a second valid/ready handshake.
- Two ping-pong banks let one matrix load while the previous one drains, giving full throughput.
- A per-matrix mode selects transpose or passthrough.

Parameters:
ELEM_W, 8, width in bits of one element (lane)
N, 4, matrix dimension: lanes per row and rows per matrix (N ≥ 2)
regSize, ELEM_W*N, width of one packed row; derived, not overridden

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of all banks and pointers; same effect as rst
in_valid  in  1  in_row is valid
in_ready  out  1  block can accept a row this cycle
in_row  in  regSize  input row; lane k at bits [regSize-1-k*ELEM_W -: ELEM_W], lane 0 most significant
in_mode  in  1  0 = transpose, 1 = passthrough; sampled only with row 0 of a matrix
out_valid  out  1  out_row is valid
out_ready  in  1  downstream accepts out_row this cycle
out_row  out  regSize  output row, same lane packing as in_row
out_last  out  1  high with the final row (row N-1) of a matrix

Behaviour:
- Reset / flush:
  - in_ready = 1; out_valid = 0; out_last = 0; out_row = 0.
  - All storage = 0; wr_bank = rd_bank = 0; wr_row = rd_row = 0.
  - Both banks EMPTY.
  - flush has priority over any handshake in the same cycle; partial or complete matrices are discarded.
- Bank states (enum): EMPTY → FILLING on first accepted row → FULL on accepting row N-1 → EMPTY after row N-1 is drained.
  - FULL is also the drain state.
- Input side:
  - in_ready = (bank[wr_bank] != FULL).
  - Accept = in_valid && in_ready; writes in_row to row wr_row of bank[wr_bank].
  - On row 0, in_mode is latched into the bank's mode bit.
  - On row N-1: bank → FULL, wr_row → 0, wr_bank toggles.
- Output side:
  - out_valid = (bank[rd_bank] == FULL).
  - Transpose mode: out_row for rd_row = j is {in_row[0].lane j, in_row[1].lane j, …, in_row[N-1].lane j}, with input row 0 in the MSBs.
  - Passthrough mode: out_row = stored row j unchanged.
  - out_last = out_valid && rd_row == N-1.
  - Transfer = out_valid && out_ready → rd_row increments. After row N-1: bank → EMPTY, rd_row → 0, rd_bank toggles.
- Latency:
  - Out row 0 is valid the cycle after row N-1 is accepted.
  - out_row, out_last and out_valid are held stable while out_valid && !out_ready.
- Throughput:
  - With out_ready held high, one row in and one row out per cycle sustained indefinitely.
  - in_ready never drops.
- Simultaneous events:
  - Writing row N-1 of one bank in the same cycle as draining row N-1 of the other is legal; both state updates apply.
  - A bank freed by a drain is writable on the next cycle, not the same cycle.
- Backpressure: both banks FULL → in_ready = 0 until the first drain of rd_bank completes.
- in_row is ignored when in_valid = 0; out_ready is ignored when out_valid = 0.

Optional Feature:
MATRIX_TRANSPOSE_STREAM_COUNT_EN
- Defined:
  - Adds output mat_count (32 bits), which increments on each completed output matrix (transfer with out_last).
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst and flush.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package transpose_pkg: bank_state_t enum (EMPTY, FILLING, FULL); default ELEM_W/N constants; function lane_sel(row, k) returning lane k of a packed row.
- Sub-module transpose_bank: one N×N element store.
  - Write port: row index, row data, mode.
  - Read port: row index; returns the transposed or passthrough row combinationally.
  - Instantiated twice.
- Top level owns the pointers, bank state and handshakes.

Test Plan:
1. N=4, ELEM_W=8, mode 0, out_ready=1; rows 0x00010203, 0x10111213, 0x20212223, 0x30313233 → out 0x00102030, 0x01112131, 0x02122232, 0x03132333; out_last on the 4th row; first out row the cycle after the 4th accept.
2. Two matrices back-to-back with out_ready=1 → in_ready constantly 1; 8 out rows contiguous after the initial latency; second matrix transposed correctly.
3. out_ready=0 while 12 rows are offered → in_ready drops after 8 accepted rows; raising out_ready for 4 cycles drains bank 0, and the next accept occurs the following cycle.
4. mode 1 with the rows from test 1 → out equals in (0x00010203 …); a following mode-0 matrix is transposed.
5. flush after 2 accepted rows (and, separately, during a drain with out_valid=1) → out_valid 0 next cycle, in_ready 1; a new full matrix afterwards yields correct output.
6. COUNT_EN defined: 3 matrices drained → mat_count = 3; rst mid-drain → mat_count = 0, out_valid = 0, out_row = 0.
